regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Architectural register file and hazard scoreboard for the 19-bit pipeline; it is the receiving end of the write-back interface. It stores 8 x 19-bit registers and serves two combinational read ports to decode. It tracks in-flight destination writes with per-register pending counters, and raises `stall` when decode needs a register that write-back has not yet committed.

## Interface
- `DATA_W`, 19, register width
- `ADDR_W`, 3, register address width
- `NUM_REGS`, 8, number of registers (2**ADDR_W)
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write-back commit strobe
- `wr_addr`  in  ADDR_W  write-back destination register
- `wr_data`  in  DATA_W  write-back data
- `rs1_addr`, `rs2_addr`  in  ADDR_W  decode source addresses
- `rs1_used`, `rs2_used`  in  1  source actually consumed by the decoded instruction
- `rs1_data`, `rs2_data`  out  DATA_W  combinational read data
- `issue_en`  in  1  decode issues an instruction that writes `issue_rd`; only valid when `stall`=0
- `issue_rd`  in  ADDR_W  destination of the issued instruction
- `stall`  out  1  combinational; decode must hold and must not issue
- `pending_mask`  out  NUM_REGS  bit i = counter i nonzero (registered state)
- `sb_err`  out  1  sticky error: issue while stalled, or issue into a saturated counter

## Operation
- Storage: 8 registers of 19 bits. All registers are writable; there is no hardwired zero.
- Write: on a `clk` edge with `wr_en`=1, `regs[wr_addr]` <= `wr_data`.
- Read: `rsN_data` = `regs[rsN_addr]`, combinational.
- Pending counter: each register has a 2-bit counter `cnt[i]`, range 0..3.
  - Issue only (`issue_en` to i, no write to i): `cnt[i]` increments.
  - Write only (`wr_en` to i, no issue to i): `cnt[i]` decrements.
  - Issue and write to the same i in one cycle: `cnt[i]` is unchanged.
  - Write to i with `cnt[i]`=0: data is written, counter stays 0, no error. Write-back strobes every cycle, so this case is normal.
- Hazard term: `src_haz(N)` = `rsN_used` & `cnt[rsN_addr]`!=0, subject to the bypass rule under Configuration.
- `stall` = `src_haz(1)` | `src_haz(2)` | (`issue_rd` counter == 3, with no same-cycle write to `issue_rd`).
- Errors:
  - `issue_en`=1 while `stall`=1: the issue is ignored (counter not incremented) and `sb_err` <= 1.
  - `sb_err` clears only on reset.
- `pending_mask[i]` = (`cnt[i]` != 0).

## Timing
- Reset (asynchronous, `reset_n`=0):
  - all registers 0, all counters 0, `sb_err`=0.
  - Therefore `rs1_data`=`rs2_data`=0, `pending_mask`=0, `stall`=0.
- Reset mid-operation: all pending state is lost immediately. Write-back must be reset concurrently.
- Write latency: data written at edge k is visible on the read ports after edge k. Without bypass, there is no same-cycle visibility.
- The counter update and the data write take effect at the same edge.
- `stall` and the read data are purely combinational from the inputs and current state; there are no added pipeline registers.

## Configuration
- Macro `REGFILE_BYPASS_EN` defined:
  - Write-to-read forwarding is enabled. If `wr_en` & `wr_addr`==`rsN_addr`, then `rsN_data`=`wr_data` in the same cycle.
  - `src_haz(N)` is suppressed when `cnt[rsN_addr]`==1 and that write is present.
- Macro undefined:
  - No forwarding. `rsN_data` always comes from the array.
  - A source with `cnt`!=0 stalls through the write-back cycle and frees one cycle later.

## Structure
- Shared package `cpu19_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`
  - typedefs `reg_data_t` (19-bit) and `reg_addr_t` (3-bit)
  - the constant `SB_CNT_MAX`=3
- One sub-module, `sb_counter`: a 2-bit saturating up/down counter.
  - Inputs: `inc`, `dec`.
  - Outputs: `busy` and `full`.
  - Instantiated once per register.

## Test plan
- Reset, then write 19'h7FFFF to r5, then read r5 one cycle later → `rs1_data`=19'h7FFFF. All other registers read 0.
- Issue to r3, then decode `rs1_addr`=3 with `rs1_used`=1 → `stall`=1 and `pending_mask`=8'h08. Then `wr_en` to r3 with 19'h00123:
  - with `REGFILE_BYPASS_EN`: `stall`=0 that cycle and `rs1_data`=19'h00123;
  - without: `stall`=0 only on the next cycle.
- Issue three times to r1 (`cnt`=3), then present `issue_rd`=1 → `stall`=1. Force `issue_en` anyway → `sb_err`=1 and `cnt` stays 3.
- Issue to r2 and write to r2 in the same cycle with `cnt[2]`=1 → `cnt[2]` remains 1 and the data is updated.
- Write to r6 with `cnt[6]`=0 → data is stored, `pending_mask`=0, `sb_err`=0.
- Assert `reset_n`=0 mid-stream with r1 pending and `sb_err`=1 → `pending_mask`=0, `sb_err`=0, reads return 0, all with no clock edge required.

Source files
------------

// File: rtl/cpu19_pkg.sv
// Shared types and constants for the 19-bit pipeline register file and scoreboard.
package cpu19_pkg;

    localparam int DATA_W   = 19;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam logic [1:0] SB_CNT_MAX = 2'd3;

endpackage

// File: rtl/sb_counter.sv
// 2-bit saturating up/down pending counter, one per architectural register.
module sb_counter
    import cpu19_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       dec,
    output logic       busy,
    output logic       full,
    output logic [1:0] count
);

    logic [1:0] cnt;

    // Simultaneous inc and dec cancel; a decrement at zero is a normal idle write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 2'd0;
        end else if (inc && !dec && cnt != SB_CNT_MAX) begin
            cnt <= cnt + 2'd1;
        end else if (dec && !inc && cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign busy  = (cnt != 2'd0);
    assign full  = (cnt == SB_CNT_MAX);
    assign count = cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// 8 x 19-bit register file with per-register pending counters and decode stall.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
    import cpu19_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic                rs1_used,
    input  logic                rs2_used,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                sb_err
);

    reg_data_t              regs [NUM_REGS];
    logic [1:0]             cnt  [NUM_REGS];
    logic [NUM_REGS-1:0]    full;
    logic [NUM_REGS-1:0]    inc;
    logic [NUM_REGS-1:0]    dec;
    logic                   issue_ok;
    logic                   wr_hit1;
    logic                   wr_hit2;
    logic                   haz1;
    logic                   haz2;
    logic                   rd_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_cnt
            sb_counter u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (inc[g]),
                .dec     (dec[g]),
                .busy    (pending_mask[g]),
                .full    (full[g]),
                .count   (cnt[g])
            );
        end
    endgenerate

    // A same-cycle write to issue_rd frees a slot, so a full counter only stalls without it.
    always_comb begin
        wr_hit1 = wr_en && (wr_addr == rs1_addr);
        wr_hit2 = wr_en && (wr_addr == rs2_addr);
        haz1    = rs1_used && (cnt[rs1_addr] != 2'd0);
        haz2    = rs2_used && (cnt[rs2_addr] != 2'd0);
`ifdef REGFILE_BYPASS_EN
        if (wr_hit1 && cnt[rs1_addr] == 2'd1) haz1 = 1'b0;
        if (wr_hit2 && cnt[rs2_addr] == 2'd1) haz2 = 1'b0;
        rs1_data = wr_hit1 ? wr_data : regs[rs1_addr];
        rs2_data = wr_hit2 ? wr_data : regs[rs2_addr];
`else
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
`endif
        rd_full  = full[issue_rd] && !(wr_en && wr_addr == issue_rd);
        stall    = haz1 || haz2 || rd_full;
        issue_ok = issue_en && !stall;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = issue_ok && (issue_rd == reg_addr_t'(i));
            dec[i] = wr_en && (wr_addr == reg_addr_t'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_err <= 1'b0;
        end else if (issue_en && stall) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
    import cpu19_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rs1_addr;
    logic [ADDR_W-1:0]   rs2_addr;
    logic                rs1_used;
    logic                rs2_used;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_rd;
    logic                stall;
    logic [NUM_REGS-1:0] pending_mask;
    logic                sb_err;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .stall        (stall),
        .pending_mask (pending_mask),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
        issue_en = 0; issue_rd = 0;
        #2;
        checks++; if (rs1_data !== 19'h0) begin failures++; $display("[TB] FAIL reset_rs1 got=%h exp=0", rs1_data); end
        checks++; if (pending_mask !== 8'h00) begin failures++; $display("[TB] FAIL reset_pending got=%h exp=00", pending_mask); end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", sb_err); end
        #10;
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        tick();
        wr_en = 1; wr_addr = 3'd5; wr_data = 19'h7FFFF;
        tick();
        wr_en = 0; rs1_addr = 3'd5;
        #1;
        checks++; if (rs1_data !== 19'h7FFFF) begin failures++; $display("[TB] FAIL wr_r5 got=%h exp=7ffff", rs1_data); end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i != 5) begin
                rs2_addr = reg_addr_t'(i);
                #1;
                checks++; if (rs2_data !== 19'h0) begin failures++; $display("[TB] FAIL rd_other r%0d got=%h exp=0", i, rs2_data); end
            end
        end
        checks++; if (pending_mask !== 8'h00) begin failures++; $display("[TB] FAIL wr_pending got=%h exp=00", pending_mask); end
    endtask

    task automatic test_hazard();
        issue_en = 1; issue_rd = 3'd3;
        tick();
        issue_en = 0; rs1_addr = 3'd3; rs1_used = 1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL haz_stall got=%b exp=1", stall); end
        checks++; if (pending_mask !== 8'h08) begin failures++; $display("[TB] FAIL haz_pending got=%h exp=08", pending_mask); end
        wr_en = 1; wr_addr = 3'd3; wr_data = 19'h00123;
        #1;
`ifdef REGFILE_BYPASS_EN
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL haz_wb_stall got=%b exp=0", stall); end
        checks++; if (rs1_data !== 19'h00123) begin failures++; $display("[TB] FAIL haz_bypass got=%h exp=00123", rs1_data); end
`else
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL haz_wb_stall got=%b exp=1", stall); end
        checks++; if (rs1_data !== 19'h0) begin failures++; $display("[TB] FAIL haz_nobypass got=%h exp=0", rs1_data); end
`endif
        tick();
        wr_en = 0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL haz_free got=%b exp=0", stall); end
        checks++; if (rs1_data !== 19'h00123) begin failures++; $display("[TB] FAIL haz_data got=%h exp=00123", rs1_data); end
        checks++; if (pending_mask !== 8'h00) begin failures++; $display("[TB] FAIL haz_clear got=%h exp=00", pending_mask); end
        rs1_used = 0;
    endtask

    task automatic test_same_cycle();
        issue_en = 1; issue_rd = 3'd2;
        tick();
        wr_en = 1; wr_addr = 3'd2; wr_data = 19'h2A5A5;
        tick();
        issue_en = 0; wr_en = 0; rs1_addr = 3'd2;
        #1;
        checks++; if (pending_mask !== 8'h04) begin failures++; $display("[TB] FAIL same_pending got=%h exp=04", pending_mask); end
        checks++; if (rs1_data !== 19'h2A5A5) begin failures++; $display("[TB] FAIL same_data got=%h exp=2a5a5", rs1_data); end
        wr_en = 1; wr_data = 19'h2A5A5;
        tick();
        wr_en = 0;
        #1;
        checks++; if (pending_mask !== 8'h00) begin failures++; $display("[TB] FAIL same_drain got=%h exp=00", pending_mask); end
    endtask

    task automatic test_zero_write();
        wr_en = 1; wr_addr = 3'd6; wr_data = 19'h13579;
        tick();
        wr_en = 0; rs2_addr = 3'd6;
        #1;
        checks++; if (rs2_data !== 19'h13579) begin failures++; $display("[TB] FAIL zero_data got=%h exp=13579", rs2_data); end
        checks++; if (pending_mask !== 8'h00) begin failures++; $display("[TB] FAIL zero_pending got=%h exp=00", pending_mask); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL zero_err got=%b exp=0", sb_err); end
    endtask

    task automatic test_saturate();
        logic [NUM_REGS-1:0] exp_mask [3] = '{8'h02, 8'h02, 8'h00};
        issue_en = 1; issue_rd = 3'd1;
        for (int i = 0; i < 3; i++) tick();
        issue_en = 0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL sat_stall got=%b exp=1", stall); end
        checks++; if (pending_mask !== 8'h02) begin failures++; $display("[TB] FAIL sat_pending got=%h exp=02", pending_mask); end
        issue_en = 1;
        tick();
        issue_en = 0;
        #1;
        checks++; if (sb_err !== 1'b1) begin failures++; $display("[TB] FAIL sat_err got=%b exp=1", sb_err); end
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL sat_still_full got=%b exp=1", stall); end
        wr_addr = 3'd1; wr_data = 19'h00042;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1;
            tick();
            wr_en = 0;
            #1;
            checks++; if (pending_mask !== exp_mask[i]) begin failures++; $display("[TB] FAIL sat_drain%0d got=%h exp=%h", i, pending_mask, exp_mask[i]); end
        end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL sat_unstall got=%b exp=0", stall); end
    endtask

    task automatic test_reset_mid();
        issue_en = 1; issue_rd = 3'd1;
        tick();
        issue_en = 0; rs1_addr = 3'd5; rs2_addr = 3'd6;
        #1;
        checks++; if (pending_mask !== 8'h02 || sb_err !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre got=%h/%b exp=02/1", pending_mask, sb_err); end
        reset_n = 1'b0;
        #1;
        checks++; if (pending_mask !== 8'h00) begin failures++; $display("[TB] FAIL mid_pending got=%h exp=00", pending_mask); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("[TB] FAIL mid_err got=%b exp=0", sb_err); end
        checks++; if (rs1_data !== 19'h0 || rs2_data !== 19'h0) begin failures++; $display("[TB] FAIL mid_data got=%h/%h exp=0/0", rs1_data, rs2_data); end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL mid_stall got=%b exp=0", stall); end
        #10;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hazard();
        test_same_cycle();
        test_zero_write();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
